dds_cordic_ctrl: RTL
====================

Name: dds_cordic_ctrl

Overview:
- Phase-sequencing controller for the 8-stage pipelined CORDIC sine/cosine generator in the DDS path.
- Runs a modulo-36000 phase accumulator in 0.01° units and adds a programmable phase offset.
- Drives the CORDIC angle and start inputs, tracks the CORDIC pipeline latency with a valid shift register, and re-registers the returned Sin/Cos with an aligned sample_valid.
- Sits between the register/config interface and the CORDIC datapath.

Parameters:
- LATENCY, 10, clock edges from an angle_o update to the corresponding cordic_sin/cordic_cos update (allowed range 2..15).
- PHASE_MAX, 36000, phase modulus in 0.01° units.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cfg_load  in  1  pulse: load ftw_i and ofs_i
- ftw_i  in  16  frequency tuning word, 0.01° per sample, valid 0..35999
- ofs_i  in  16  phase offset, 0.01°, valid 0..35999
- cfg_err  out  1  one-cycle pulse: config rejected
- start  in  1  pulse: begin generation
- stop  in  1  pulse: end generation
- busy  out  1  high in RUN or FLUSH
- done  out  1  one-cycle pulse when FLUSH completes
- angle_o  out  16  angle to CORDIC, 0..35999
- cordic_start  out  1  CORDIC start/enable, equal to busy
- cordic_sin  in  8  signed Sin from CORDIC
- cordic_cos  in  8  signed Cos from CORDIC
- sin_o  out  8  signed registered sine sample
- cos_o  out  8  signed registered cosine sample
- sample_valid  out  1  sin_o/cos_o hold a sample issued during RUN

Behaviour:
- Reset (async, rst_n low): state IDLE; ftw=0, ofs=0, acc=0, valid_sr=0. All outputs 0: angle_o, sin_o, cos_o, sample_valid, busy, done, cfg_err, cordic_start. Reset mid-RUN or mid-FLUSH aborts immediately, with no done pulse.
- Arithmetic: 17-bit intermediate. next = acc+ftw; if next≥36000, subtract 36000. angle = acc+ofs; if ≥36000, subtract 36000. A single conditional subtract suffices because both operands are ≤35999.
- FSM IDLE:
  - cfg_load with ftw_i≤35999 and ofs_i≤35999 loads both registers.
  - cfg_load with either value >35999 pulses cfg_err on the next cycle and leaves both registers unchanged.
  - start → RUN with acc cleared to 0 (phase-coherent restart).
  - stop is ignored.
  - start and cfg_load in the same cycle: config loads and start is accepted; the new values are used from the first sample.
- FSM RUN: every cycle, angle_o <= (acc+ofs) mod 36000, acc <= next, valid_sr <= {valid_sr, 1}.
  - start is ignored.
  - cfg_load pulses cfg_err and makes no change.
  - stop → FLUSH, and no sample is issued on that edge.
  - start and stop together: stop wins.
- FSM FLUSH: angle_o holds its last value; valid_sr shifts in 0 each cycle; cfg_load → cfg_err; start and stop are ignored. When valid_sr is all zero → IDLE with a done pulse on the same edge.
- Output alignment:
  - sin_o/cos_o <= cordic_sin/cordic_cos every cycle.
  - sample_valid = valid_sr[LATENCY], with valid_sr being LATENCY+1 bits wide.
  - A sample issued at edge E is valid at edge E+LATENCY+1.
- First-sample timing: start sampled at E0, first angle_o = ofs at E1, first sample_valid at E1+LATENCY+1.
- ftw=0 produces a constant angle_o = ofs; this is legal.
- busy = (state≠IDLE); cordic_start = busy.

Optional Feature:
- Macro DDS_BURST_EN.
- When defined:
  - Adds input burst_len_i[15:0], loaded together with ftw/ofs on an accepted cfg_load.
  - A 16-bit sample counter is cleared on start and counts issued samples.
  - RUN → FLUSH automatically after exactly burst_len samples.
  - burst_len=0 means continuous operation.
  - An explicit stop still ends RUN early.
- When not defined: no burst_len port or counter; RUN continues until stop.

Test Plan:
- ftw=9000, ofs=0, start: angle_o sequence 0, 9000, 18000, 27000, 0, 9000…; first sample_valid exactly LATENCY+1 edges after the first angle_o.
- ftw=35999, ofs=30000: acc 0, 35999, 35998…; angle_o 30000, 29999, 29998…; no value ≥36000 ever appears.
- cfg_load ftw=36000 in IDLE → cfg_err pulse, ftw unchanged. cfg_load ftw=100 during RUN → cfg_err pulse, increments stay at the old ftw.
- After 5 samples, stop: sample_valid is high for exactly 5 cycles in total; done pulses when the last valid sample drains; busy drops the same edge; sin_o/cos_o match a CORDIC model for angles 0, ftw, 2·ftw…
- rst_n low for 1 cycle mid-RUN → all outputs 0 asynchronously; no done pulse; a subsequent start restarts from acc=0.
- (DDS_BURST_EN) burst_len=4, ftw=4500 → exactly 4 angles 0, 4500, 9000, 13500, then FLUSH, 4 sample_valid cycles, one done pulse. Repeat with burst_len=0: runs until stop.

Source files
------------

// File: rtl/dds_cordic_ctrl_if.sv
// Config, control and CORDIC-side signal bundle for dds_cordic_ctrl.
// Optional DDS_BURST_EN adds burst_len_i to the bundle.
interface dds_cordic_ctrl_if;
    logic               cfg_load;
    logic [15:0]        ftw_i;
    logic [15:0]        ofs_i;
`ifdef DDS_BURST_EN
    logic [15:0]        burst_len_i;
`endif
    logic               cfg_err;
    logic               start;
    logic               stop;
    logic               busy;
    logic               done;
    logic [15:0]        angle_o;
    logic               cordic_start;
    logic signed [7:0]  cordic_sin;
    logic signed [7:0]  cordic_cos;
    logic signed [7:0]  sin_o;
    logic signed [7:0]  cos_o;
    logic               sample_valid;

    modport slave (
`ifdef DDS_BURST_EN
        input  burst_len_i,
`endif
        input  cfg_load, ftw_i, ofs_i, start, stop, cordic_sin, cordic_cos,
        output cfg_err, busy, done, angle_o, cordic_start, sin_o, cos_o, sample_valid
    );

    modport master (
`ifdef DDS_BURST_EN
        output burst_len_i,
`endif
        output cfg_load, ftw_i, ofs_i, start, stop, cordic_sin, cordic_cos,
        input  cfg_err, busy, done, angle_o, cordic_start, sin_o, cos_o, sample_valid
    );
endinterface

// File: rtl/dds_cordic_ctrl.sv
// Phase sequencer for a pipelined CORDIC: modulo phase accumulator, offset, latency-tracked valid.
// Optional feature macro DDS_BURST_EN: auto-stop after a programmable number of samples.
module dds_cordic_ctrl #(
    parameter int unsigned LATENCY   = 10,
    parameter int unsigned PHASE_MAX = 36000
) (
    input  logic              clk,
    input  logic              rst_n,
    dds_cordic_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

    localparam logic [16:0] PMAX = 17'(PHASE_MAX);

    state_t               state_q, state_d;
    logic [15:0]          ftw_q, ftw_d;
    logic [15:0]          ofs_q, ofs_d;
    logic [15:0]          acc_q, acc_d;
    logic [15:0]          angle_q, angle_d;
    logic [LATENCY:0]     valid_sr_q, valid_sr_d;
    logic                 cfg_err_q, cfg_err_d;
    logic                 done_q, done_d;
    logic                 sample_valid_q;
    logic signed [7:0]    sin_q, cos_q;
`ifdef DDS_BURST_EN
    logic [15:0]          burst_q, burst_d;
    logic [15:0]          cnt_q, cnt_d;
    logic                 burst_last;
`endif

    logic [16:0]          acc_sum, ang_sum;
    logic [15:0]          acc_wrap, ang_wrap;
    logic                 cfg_ok;

    // Operands are both below PHASE_MAX, so one conditional subtract wraps correctly.
    assign acc_sum  = {1'b0, acc_q} + {1'b0, ftw_q};
    assign ang_sum  = {1'b0, acc_q} + {1'b0, ofs_q};
    assign acc_wrap = (acc_sum >= PMAX) ? 16'(acc_sum - PMAX) : acc_sum[15:0];
    assign ang_wrap = (ang_sum >= PMAX) ? 16'(ang_sum - PMAX) : ang_sum[15:0];
    assign cfg_ok   = ({1'b0, bus.ftw_i} < PMAX) && ({1'b0, bus.ofs_i} < PMAX);

`ifdef DDS_BURST_EN
    assign burst_last = (burst_q != 16'd0) && (({1'b0, cnt_q} + 17'd1) == {1'b0, burst_q});
`endif

    always_comb begin
        state_d    = state_q;
        ftw_d      = ftw_q;
        ofs_d      = ofs_q;
        acc_d      = acc_q;
        angle_d    = angle_q;
        valid_sr_d = valid_sr_q;
        cfg_err_d  = 1'b0;
        done_d     = 1'b0;
`ifdef DDS_BURST_EN
        burst_d    = burst_q;
        cnt_d      = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.cfg_load) begin
                    if (cfg_ok) begin
                        ftw_d = bus.ftw_i;
                        ofs_d = bus.ofs_i;
`ifdef DDS_BURST_EN
                        burst_d = bus.burst_len_i;
`endif
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
                if (bus.start) begin
                    state_d = S_RUN;
                    acc_d   = 16'd0;
`ifdef DDS_BURST_EN
                    cnt_d   = 16'd0;
`endif
                end
            end
            S_RUN: begin
                cfg_err_d = bus.cfg_load;
                if (bus.stop) begin
                    state_d    = S_FLUSH;
                    valid_sr_d = {valid_sr_q[LATENCY-1:0], 1'b0};
                end else begin
                    angle_d    = ang_wrap;
                    acc_d      = acc_wrap;
                    valid_sr_d = {valid_sr_q[LATENCY-1:0], 1'b1};
`ifdef DDS_BURST_EN
                    cnt_d      = cnt_q + 16'd1;
                    if (burst_last) begin
                        state_d = S_FLUSH;
                    end
`endif
                end
            end
            S_FLUSH: begin
                cfg_err_d  = bus.cfg_load;
                valid_sr_d = {valid_sr_q[LATENCY-1:0], 1'b0};
                // Leave only once every in-flight sample has reached sample_valid.
                if (valid_sr_q == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            ftw_q          <= 16'd0;
            ofs_q          <= 16'd0;
            acc_q          <= 16'd0;
            angle_q        <= 16'd0;
            valid_sr_q     <= '0;
            cfg_err_q      <= 1'b0;
            done_q         <= 1'b0;
            sample_valid_q <= 1'b0;
            sin_q          <= 8'sd0;
            cos_q          <= 8'sd0;
`ifdef DDS_BURST_EN
            burst_q        <= 16'd0;
            cnt_q          <= 16'd0;
`endif
        end else begin
            state_q        <= state_d;
            ftw_q          <= ftw_d;
            ofs_q          <= ofs_d;
            acc_q          <= acc_d;
            angle_q        <= angle_d;
            valid_sr_q     <= valid_sr_d;
            cfg_err_q      <= cfg_err_d;
            done_q         <= done_d;
            // valid_sr[LATENCY] tracks the CORDIC output; one more stage matches the sin/cos register.
            sample_valid_q <= valid_sr_q[LATENCY];
            sin_q          <= bus.cordic_sin;
            cos_q          <= bus.cordic_cos;
`ifdef DDS_BURST_EN
            burst_q        <= burst_d;
            cnt_q          <= cnt_d;
`endif
        end
    end

    assign bus.busy         = (state_q != S_IDLE);
    assign bus.cordic_start = (state_q != S_IDLE);
    assign bus.done         = done_q;
    assign bus.cfg_err      = cfg_err_q;
    assign bus.angle_o      = angle_q;
    assign bus.sin_o        = sin_q;
    assign bus.cos_o        = cos_q;
    assign bus.sample_valid = sample_valid_q;
endmodule
